mult_control: RTL and testbench
===============================

// Module: mult_control
// PURPOSE
//  Control unit for the 8-bit signed add-shift multiplier datapath (X|A|B registers, 9-bit adder).
//  Sequences one multiplication per Run press: clear A/X, WIDTH add/sub-then-shift steps, wait for Run release.
//  Sits between the switch/button inputs and the register-unit/adder controls inside lab5_toplevel.
//  Product is left in A:B.
// PARAMETERS
//  WIDTH   8   multiplier width = number of add/shift steps; counter is $clog2(WIDTH) bits
// PORTS
//  Clk           in   1  system clock, rising edge
//  Reset         in   1  synchronous, active-low; returns FSM to IDLE
//  Run           in   1  active-low start button; level, already debounced
//  ClearA_LoadB  in   1  active-low; load S into B, clear A and X (IDLE only)
//  M             in   1  B[0], current multiplier bit
//  LoadB         out  1  load S into B, clear A and X this cycle
//  ClearAX       out  1  clear A and X this cycle; B kept, so products can chain
//  Add           out  1  A <= A + S; X <= sign of 9-bit sum
//  Sub           out  1  A <= A - S (adder with S inverted, carry-in 1); X <= sign
//  Shift         out  1  arithmetic right shift of X|A|B by 1; X is replicated
//  Busy          out  1  state != IDLE
//  Done          out  1  high in HOLD (product valid, waiting for Run release)
// BEHAVIOUR
//  - States: IDLE, CLR, ADD, SHIFT, HOLD. cnt = step counter.
//  - All outputs are decoded combinationally from the state, cnt and M.
//  - Outputs are mutually exclusive: at most one of LoadB/ClearAX/Add/Sub/Shift is high in any cycle.
//  - Reset==0 at an edge: state<=IDLE, cnt<=0. While Reset==0, all outputs are forced to 0.
//    Reset wins over every other input in any state, including mid-sequence.
//  - IDLE:
//    - Run==0 -> CLR (Run has priority over ClearA_LoadB).
//    - Otherwise LoadB = ~ClearA_LoadB, level, each cycle it is held.
//  - CLR: ClearAX=1; cnt<=0; -> ADD.
//  - ADD:
//    - M==1 and cnt<WIDTH-1 -> Add=1.
//    - M==1 and cnt==WIDTH-1 -> Sub=1 (sign-bit weight is negative).
//    - M==0 -> no control asserted.
//    - Always -> SHIFT.
//  - SHIFT: Shift=1.
//    - cnt==WIDTH-1 -> HOLD.
//    - Otherwise cnt<=cnt+1 -> ADD.
//  - HOLD: Done=1. Run==1 -> IDLE; otherwise stay.
//    This guarantees exactly one multiply per press, however long Run is held.
//  - Latency: Run sampled low at edge n -> CLR in cycle n+1 -> first ADD in cycle n+2.
//    Last SHIFT is in cycle n+2*WIDTH+1 (n+17); HOLD/Done from n+2*WIDTH+2 (n+18).
//  - Exactly WIDTH Shift pulses and at most one Sub pulse per sequence.
//  - cnt never exceeds WIDTH-1; no wrap-around.
//  - ClearA_LoadB is ignored outside IDLE. A change of S mid-sequence is a datapath concern, not checked here.
//  - Run released mid-sequence does not abort; the FSM finishes and passes straight through HOLD to IDLE.
//  - Simultaneous Run==0 and ClearA_LoadB==0 in IDLE: go to CLR; LoadB stays 0.
// TESTING
//  1. Reset=0 for 2 cycles in any state -> IDLE; all outputs 0; Busy=0; Done=0.
//  2. IDLE, ClearA_LoadB=0 for 3 cycles, Run=1 -> LoadB=1 for exactly 3 cycles.
//     With Run=0 also low -> LoadB stays 0; CLR next cycle.
//  3. M tied 1, Run low -> ClearAX 1 cycle.
//     Then 7x (Add, Shift), then Sub, Shift -> 8 Shifts; Done at cycle n+18.
//     Run held low 40 cycles -> no second sequence.
//  4. Datapath-connected checks:
//     - Load 7, run with 59 -> A=8'h01, B=8'h9D.
//     - 7*-59 -> 8'hFE/8'h63.
//     - -7*59 -> 8'hFE/8'h63.
//     - -7*-59 -> 8'h01/8'h9D.
//  5. Load -2, then 4 chained runs with S=-2 -> A=8'hFF, B=8'hE0.
//     ClearA_LoadB pulsed while Busy -> no LoadB and result unchanged.
//  6. Reset=0 at the 4th SHIFT -> IDLE next edge; no further Shift/Add/Sub.
//     Next Run press gives a full, correct sequence.

Source files
------------

// File: rtl/mult_control.sv
// Sequencer for the 8-bit signed add-shift multiplier: one multiply per Run press,
// WIDTH add/sub-then-shift steps, product left in A:B, then waits for Run release.
module mult_control #(
  parameter int WIDTH = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       ClearA_LoadB,
  input  logic       M,
  output logic       LoadB,
  output logic       ClearAX,
  output logic       Add,
  output logic       Sub,
  output logic       Shift,
  output logic       Busy,
  output logic       Done,
  output logic [2:0] o_dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE:  if (!Run) r_state <= S_CLR;
        S_CLR: begin
          r_cnt   <= '0;
          r_state <= S_ADD;
        end
        S_ADD:   r_state <= S_SHIFT;
        S_SHIFT: begin
          if (w_last) begin
            r_state <= S_HOLD;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= S_ADD;
          end
        end
        // Only a released Run re-arms, so a long press yields one product.
        S_HOLD:  if (Run) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    LoadB   = 1'b0;
    ClearAX = 1'b0;
    Add     = 1'b0;
    Sub     = 1'b0;
    Shift   = 1'b0;
    Done    = 1'b0;
    Busy    = 1'b0;
    if (Reset) begin
      Busy = (r_state != S_IDLE);
      case (r_state)
        S_IDLE:  LoadB = Run & ~ClearA_LoadB;
        S_CLR:   ClearAX = 1'b1;
        // The top multiplier bit carries negative weight, hence Sub on the last step.
        S_ADD: begin
          if (M) begin
            if (w_last) Sub = 1'b1;
            else        Add = 1'b1;
          end
        end
        S_SHIFT: Shift = 1'b1;
        S_HOLD:  Done = 1'b1;
        default: ;
      endcase
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mult_control.sv
// Bench for mult_control: a behavioural X|A|B datapath closes the loop, and a
// scoreboard compares product and pulse counts each time Done rises.
module tb_mult_control;

  localparam int W = 28;  // {A[8], B[8], shifts[4], adds[4], subs[4]}

  logic       clk;
  logic       rst_n;
  logic       run_n;
  logic       clb_n;
  logic       m_in;
  logic       load_b, clear_ax, add, sub, shift, busy, done;
  logic [2:0] dbg_state;

  logic [7:0] s_val;
  logic [7:0] dp_a, dp_b;
  logic       dp_x;
  logic       m_tie;

  logic [W-1:0] exp_q[$];
  int checks;
  int failures;

  mult_control #(.WIDTH(8)) dut (
    .Clk         (clk),
    .Reset       (rst_n),
    .Run         (run_n),
    .ClearA_LoadB(clb_n),
    .M           (m_in),
    .LoadB       (load_b),
    .ClearAX     (clear_ax),
    .Add         (add),
    .Sub         (sub),
    .Shift       (shift),
    .Busy        (busy),
    .Done        (done),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- datapath model ----------------
  function automatic logic [8:0] addsub(input logic [7:0] a, input logic [7:0] s, input logic do_sub);
    logic [8:0] r;
    if (do_sub) r = {a[7], a} + {~s[7], ~s} + 9'd1;
    else        r = {a[7], a} + {s[7], s};
    return r;
  endfunction

  assign m_in = m_tie ? 1'b1 : dp_b[0];

  initial begin
    dp_a = 8'h00;
    dp_b = 8'h00;
    dp_x = 1'b0;
  end

  always @(posedge clk) begin
    logic [8:0] r;
    if (load_b) begin
      dp_b <= s_val; dp_a <= 8'h00; dp_x <= 1'b0;
    end else if (clear_ax) begin
      dp_a <= 8'h00; dp_x <= 1'b0;
    end else if (add || sub) begin
      r = addsub(dp_a, s_val, sub);
      dp_a <= r[7:0]; dp_x <= r[8];
    end else if (shift) begin
      {dp_x, dp_a, dp_b} <= {dp_x, dp_x, dp_a, dp_b[7:1]};
    end
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int  mon_sh, mon_ad, mon_sb;
  logic done_d;
  initial begin
    mon_sh = 0; mon_ad = 0; mon_sb = 0; done_d = 1'b0;
  end

  always @(negedge clk) begin
    logic [W-1:0] got, exp;
    chk("onehot_ctrl", 32'($countones({load_b, clear_ax, add, sub, shift}) <= 1), 32'd1);
    if (clear_ax) begin
      mon_sh = 0; mon_ad = 0; mon_sb = 0;
    end
    if (shift) mon_sh++;
    if (add)   mon_ad++;
    if (sub)   mon_sb++;
    if (done && !done_d) begin
      got = {dp_a, dp_b, mon_sh[3:0], mon_ad[3:0], mon_sb[3:0]};
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(got), 32'hFFFFFFFF);
      end else begin
        exp = exp_q.pop_front();
        chk("product_{A,B,sh,add,sub}", 32'(got), 32'(exp));
      end
    end
    done_d = done;
  end

  // ---------------- driver tasks ----------------
  task automatic load_b_reg(input logic [7:0] s);
    @(negedge clk);
    s_val = s; clb_n = 1'b0;
    @(negedge clk);
    clb_n = 1'b1;
  endtask

  task automatic run_seq(input logic [7:0] s, input logic clb_low, input int hold,
                         input logic [7:0] ea, input logic [7:0] eb,
                         input logic [3:0] eadd, input logic [3:0] esub);
    int clr_cnt, clr_p, done_p, lb_cnt;
    clr_cnt = 0; clr_p = 0; done_p = 0; lb_cnt = 0;
    exp_q.push_back({ea, eb, 4'd8, eadd, esub});
    @(negedge clk);
    s_val = s; run_n = 1'b0; clb_n = clb_low ? 1'b0 : 1'b1;
    #1;
    chk("loadb_with_run", 32'(load_b), 32'd0);
    for (int p = 1; p <= hold; p++) begin
      @(posedge clk);
      @(negedge clk);
      if (clear_ax) begin
        clr_cnt++;
        if (clr_p == 0) clr_p = p;
      end
      if (load_b) lb_cnt++;
      if (done && done_p == 0) done_p = p;
    end
    chk("clr_latency", 32'(clr_p), 32'd1);
    chk("done_latency", 32'(done_p), 32'd18);
    chk("clr_count", 32'(clr_cnt), 32'd1);
    chk("loadb_busy", 32'(lb_cnt), 32'd0);
    chk("hold_done", 32'(done), 32'd1);
    run_n = 1'b1; clb_n = 1'b1;
    @(negedge clk);
    chk("idle_after_release", 32'({busy, done}), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt, sh;
    checks = 0; failures = 0;
    rst_n = 1'b0; run_n = 1'b1; clb_n = 1'b1; s_val = 8'h00; m_tie = 1'b0;

    // Reset: outputs forced low even with ClearA_LoadB asserted
    @(negedge clk);
    clb_n = 1'b0; #1;
    chk("reset_outs_0", 32'({load_b, clear_ax, add, sub, shift, busy, done}), 32'd0);
    @(negedge clk);
    chk("reset_outs_1", 32'({load_b, clear_ax, add, sub, shift, busy, done}), 32'd0);
    clb_n = 1'b1; rst_n = 1'b1; #1;
    chk("idle_outs", 32'({load_b, clear_ax, add, sub, shift, busy, done}), 32'd0);
    chk("idle_state", 32'(dbg_state), 32'd0);

    // LoadB is a level: 3 cycles held -> 3 cycles of LoadB
    s_val = 8'd7; cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      clb_n = (i < 3) ? 1'b0 : 1'b1;
      #1;
      if (load_b) cnt++;
    end
    chk("loadb_cycles", 32'(cnt), 32'd3);

    // Run and ClearA_LoadB low together: Run wins; 7*59
    run_seq(8'd59, 1'b1, 20, 8'h01, 8'h9D, 4'd3, 4'd0);
    load_b_reg(8'd7);
    run_seq(8'hC5, 1'b0, 20, 8'hFE, 8'h63, 4'd3, 4'd0);   // 7*-59
    load_b_reg(8'hF9);
    run_seq(8'd59, 1'b0, 20, 8'hFE, 8'h63, 4'd5, 4'd1);   // -7*59
    load_b_reg(8'hF9);
    run_seq(8'hC5, 1'b0, 20, 8'h01, 8'h9D, 4'd5, 4'd1);   // -7*-59

    // M tied high acts as multiplier -1; Run held 40 cycles -> single sequence
    m_tie = 1'b1;
    run_seq(8'd5, 1'b0, 40, 8'hFF, 8'hFB, 4'd7, 4'd1);
    m_tie = 1'b0;

    // Chained products from B = -2, S = -2; ClearA_LoadB held low during one run
    load_b_reg(8'hFE);
    run_seq(8'hFE, 1'b0, 20, 8'h00, 8'h04, 4'd6, 4'd1);
    run_seq(8'hFE, 1'b1, 20, 8'hFF, 8'hF8, 4'd1, 4'd0);
    run_seq(8'hFE, 1'b0, 20, 8'h00, 8'h10, 4'd4, 4'd1);
    run_seq(8'hFE, 1'b0, 20, 8'hFF, 8'hE0, 4'd1, 4'd0);

    // Reset asserted during the 4th Shift aborts the sequence
    load_b_reg(8'd7);
    @(negedge clk);
    s_val = 8'd59; run_n = 1'b0; sh = 0;
    for (int p = 0; p < 30 && sh < 4; p++) begin
      @(posedge clk);
      @(negedge clk);
      if (shift) sh++;
    end
    chk("reached_4th_shift", 32'(sh), 32'd4);
    rst_n = 1'b0; #1;
    chk("abort_outs_forced", 32'({load_b, clear_ax, add, sub, shift, busy, done}), 32'd0);
    @(negedge clk);
    chk("abort_state_idle", 32'(dbg_state), 32'd0);
    rst_n = 1'b1; run_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (add || sub || shift || clear_ax || busy || done) cnt++;
    end
    chk("abort_quiet", 32'(cnt), 32'd0);
    load_b_reg(8'd7);
    run_seq(8'd59, 1'b0, 20, 8'h01, 8'h9D, 4'd3, 4'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
